// File: rtl/tty_write_controller.sv
// Terminal-style writer for the character buffer: prints bytes, handles CR/LF/BS/TAB/FF,
// and sequences screen and line clears. Define TTY_AUTOWRAP_EN to wrap at the last column.
module tty_write_controller #(
  parameter int         CHAR_HORZ_CNT = 16,
  parameter int         CHAR_VERT_CNT = 2,
  parameter int         CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
  parameter int         CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
  parameter logic [7:0] CLEAR_SYMBOL  = 8'h20,
  parameter int         TAB_STOP      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [CHAR_HORZ_W-1:0] char_hpos,
  output logic [CHAR_VERT_W-1:0] char_vpos,
  output logic                   char_write_en,
  output logic [7:0]             char_symbol,
  output logic                   cursor_valid,
  output logic [CHAR_HORZ_W-1:0] cursor_hpos,
  output logic [CHAR_VERT_W-1:0] cursor_vpos
);

  typedef enum logic [1:0] {SCREEN_CLR, LINE_CLR, IDLE} state_t;

  localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
  localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
  localparam logic [CHAR_HORZ_W-1:0] H_ONE  = CHAR_HORZ_W'(1);
  localparam logic [CHAR_VERT_W-1:0] V_ONE  = CHAR_VERT_W'(1);

  state_t                 r_state, w_state_next;
  logic [CHAR_HORZ_W-1:0] r_sweep_h, w_sweep_h;
  logic [CHAR_VERT_W-1:0] r_sweep_v, w_sweep_v;
  logic                   r_wr_en, w_wr_en;
  logic [CHAR_HORZ_W-1:0] r_wr_h, w_wr_h;
  logic [CHAR_VERT_W-1:0] r_wr_v, w_wr_v;
  logic [7:0]             r_wr_sym, w_wr_sym;
  logic                   r_cur_valid, w_cur_valid;
  logic [CHAR_HORZ_W-1:0] r_cur_h, w_cur_h;
  logic [CHAR_VERT_W-1:0] r_cur_v, w_cur_v;

  logic                   w_accept;
  logic                   w_is_print;
  logic                   w_at_end;
  logic                   w_wrap;
  logic                   w_tab_ovf;
  logic                   w_row_adv;
  logic                   w_sweep_done;
  logic [CHAR_VERT_W-1:0] w_cur_v_inc;
  logic [31:0]            w_tab_sum;

  assign w_accept     = in_valid && (r_state == IDLE);
  assign w_is_print   = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_at_end     = (r_cur_h == H_LAST);
  assign w_cur_v_inc  = (r_cur_v == V_LAST) ? '0 : r_cur_v + V_ONE;
  assign w_tab_sum    = (32'(r_cur_h) | 32'(TAB_STOP - 1)) + 32'd1;
  assign w_tab_ovf    = (w_tab_sum >= 32'(CHAR_HORZ_CNT));
  assign w_sweep_done = (r_sweep_h == H_LAST) && (r_sweep_v == V_LAST);

`ifdef TTY_AUTOWRAP_EN
  assign w_wrap = w_accept && w_is_print && w_at_end;
`else
  assign w_wrap = 1'b0;
`endif

  assign w_row_adv = w_wrap ||
                     (w_accept && (in_data == 8'h0A)) ||
                     (w_accept && (in_data == 8'h09) && w_tab_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SCREEN_CLR;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      SCREEN_CLR: if (w_sweep_done) w_state_next = IDLE;
      LINE_CLR:   if (r_sweep_h == H_LAST) w_state_next = IDLE;
      IDLE: begin
        if (w_accept && (in_data == 8'h0C)) w_state_next = SCREEN_CLR;
        else if (w_row_adv)                 w_state_next = LINE_CLR;
      end
      default:    w_state_next = SCREEN_CLR;
    endcase
  end

  always_comb begin
    w_sweep_h   = r_sweep_h;
    w_sweep_v   = r_sweep_v;
    w_wr_en     = 1'b0;
    w_wr_h      = r_wr_h;
    w_wr_v      = r_wr_v;
    w_wr_sym    = r_wr_sym;
    w_cur_valid = r_cur_valid;
    w_cur_h     = r_cur_h;
    w_cur_v     = r_cur_v;
    unique case (r_state)
      SCREEN_CLR: begin
        w_wr_en  = 1'b1;
        w_wr_h   = r_sweep_h;
        w_wr_v   = r_sweep_v;
        w_wr_sym = CLEAR_SYMBOL;
        if (r_sweep_h == H_LAST) begin
          w_sweep_h = '0;
          w_sweep_v = (r_sweep_v == V_LAST) ? '0 : r_sweep_v + V_ONE;
        end else begin
          w_sweep_h = r_sweep_h + H_ONE;
        end
        if (w_sweep_done) begin
          w_cur_valid = 1'b1;
          w_cur_h     = '0;
          w_cur_v     = '0;
        end
      end
      LINE_CLR: begin
        // Cursor row was already advanced on the accepting edge.
        w_wr_en   = 1'b1;
        w_wr_h    = r_sweep_h;
        w_wr_v    = r_cur_v;
        w_wr_sym  = CLEAR_SYMBOL;
        w_sweep_h = (r_sweep_h == H_LAST) ? '0 : r_sweep_h + H_ONE;
      end
      IDLE: begin
        if (w_accept) begin
          w_sweep_h = '0;
          w_sweep_v = '0;
          if (w_is_print) begin
            w_wr_en  = 1'b1;
            w_wr_h   = r_cur_h;
            w_wr_v   = r_cur_v;
            w_wr_sym = in_data;
            if (w_wrap) begin
              w_cur_h = '0;
              w_cur_v = w_cur_v_inc;
            end else if (!w_at_end) begin
              w_cur_h = r_cur_h + H_ONE;
            end
          end else begin
            case (in_data)
              8'h0D: w_cur_h = '0;
              8'h0A: begin
                w_cur_h = '0;
                w_cur_v = w_cur_v_inc;
              end
              8'h08: begin
                if (r_cur_h != '0) begin
                  w_wr_en  = 1'b1;
                  w_wr_h   = r_cur_h - H_ONE;
                  w_wr_v   = r_cur_v;
                  w_wr_sym = CLEAR_SYMBOL;
                  w_cur_h  = r_cur_h - H_ONE;
                end
              end
              8'h09: begin
                if (w_tab_ovf) begin
                  w_cur_h = '0;
                  w_cur_v = w_cur_v_inc;
                end else begin
                  w_cur_h = w_tab_sum[CHAR_HORZ_W-1:0];
                end
              end
              8'h0C: begin
                w_cur_valid = 1'b0;
                w_cur_h     = '0;
                w_cur_v     = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep_h   <= '0;
      r_sweep_v   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_h      <= '0;
      r_wr_v      <= '0;
      r_wr_sym    <= 8'h00;
      r_cur_valid <= 1'b0;
      r_cur_h     <= '0;
      r_cur_v     <= '0;
    end else begin
      r_sweep_h   <= w_sweep_h;
      r_sweep_v   <= w_sweep_v;
      r_wr_en     <= w_wr_en;
      r_wr_h      <= w_wr_h;
      r_wr_v      <= w_wr_v;
      r_wr_sym    <= w_wr_sym;
      r_cur_valid <= w_cur_valid;
      r_cur_h     <= w_cur_h;
      r_cur_v     <= w_cur_v;
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign char_hpos     = r_wr_h;
  assign char_vpos     = r_wr_v;
  assign char_write_en = r_wr_en;
  assign char_symbol   = r_wr_sym;
  assign cursor_valid  = r_cur_valid;
  assign cursor_hpos   = r_cur_h;
  assign cursor_vpos   = r_cur_v;

endmodule
